// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: op codes, FSM states and the flag vector.
// Flags are ordered {V, C, N, Zf} from MSB to LSB.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8,
    OP_MUL = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic zf;
  } flags_t;

  localparam logic [3:0] OP_LAST = 4'd9;

endpackage

// File: rtl/alu_seq_if.sv
// Issue-side and writeback-side handshake bundle for alu_seq.
// master = operand/issue logic plus writeback consumer, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  import alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z;
  flags_t           flags;
  logic             err;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, Z, flags, err
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, Z, flags, err
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier (built only with ALU_SEQ_MUL_EN): one partial product per cycle,
// done pulses WIDTH cycles after start; no backpressure, prod holds until the next start.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, A};
      mplier_d = B;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      // Multiplicand walks left while the multiplier LSB selects it.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign prod = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: 1-cycle ops, WIDTH+1-cycle MUL when ALU_SEQ_MUL_EN is defined (else op 9 is illegal).
// Result held until out_ready; in_ready = IDLE or (DONE && out_ready), giving 1 op/cycle streaming.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] z;
    flags_t           f;
    logic             err;
  } res_t;

  function automatic res_t alu_op(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [3:0]       op);
    res_t           r;
    logic [WIDTH:0] wide;
    logic [SHW-1:0] sh;
    r    = '0;
    wide = '0;
    sh   = b[SHW-1:0];
    case (op)
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        r.z     = wide[WIDTH-1:0];
        r.f.c   = wide[WIDTH];
        r.f.v   = (a[WIDTH-1] == b[WIDTH-1]) && (r.z[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r.z     = a - b;
        r.f.c   = (a >= b);
        r.f.v   = (a[WIDTH-1] != b[WIDTH-1]) && (r.z[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  r.z = a & b;
      OP_OR:   r.z = a | b;
      OP_XOR:  r.z = a ^ b;
      OP_NOT:  r.z = ~a;
      OP_SLL:  r.z = a << sh;
      OP_SRL:  r.z = a >> sh;
      OP_SRA:  r.z = $signed(a) >>> sh;
      // MUL is routed to the multiplier before reaching here, so op 9 lands as illegal.
      default: r.err = 1'b1;
    endcase
    if (!r.err) begin
      r.f.n  = r.z[WIDTH-1];
      r.f.zf = (r.z == '0);
    end
    return r;
  endfunction

  state_e state_q, state_d;
  res_t   res_q, res_d;
  logic   in_ready_c;
  logic   accept;

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  function automatic res_t mul_res(input logic [2*WIDTH-1:0] p);
    res_t r;
    r      = '0;
    r.z    = p[WIDTH-1:0];
    r.f.c  = |p[2*WIDTH-1:WIDTH];
    r.f.n  = r.z[WIDTH-1];
    r.f.zf = (r.z == '0);
    return r;
  endfunction

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .A     (bus.A),
    .B     (bus.B),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`endif

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
`ifdef ALU_SEQ_MUL_EN
    mul_start  = 1'b0;
`endif
    in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    accept     = bus.in_valid && in_ready_c;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (bus.op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            res_d   = alu_op(bus.A, bus.B, bus.op);
            state_d = DONE;
          end
`else
          res_d   = alu_op(bus.A, bus.B, bus.op);
          state_d = DONE;
`endif
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          res_d   = mul_res(mul_prod);
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.Z         = res_q.z;
  assign bus.flags     = res_q.f;
  assign bus.err       = res_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed vector table, hand-written handshake/reset
// sequences, and random ops scored against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int MUL_LAT = MUL_EN ? W + 1 : 1;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_tot;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] z;
    logic [3:0] f;
    logic       e;
    int         lat;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                              input logic [7:0] z, input logic [3:0] f, input logic e,
                              input int lat, input string nm);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.z = z; v.f = f; v.e = e; v.lat = lat; v.nm = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic on the op definitions.
  task automatic model(input int a, input int b, input int o,
                       output int z, output int f, output int e, output int lat);
    int sa, sb, r, sh, v, c;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sh = b % W;
    z = 0; v = 0; c = 0; e = 0; lat = 1;
    case (o)
      0: begin r = a + b; z = r % 256; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      1: begin z = (a - b + 256) % 256; c = (a >= b); v = (sa - sb > 127) || (sa - sb < -128); end
      2: z = a & b;
      3: z = a | b;
      4: z = a ^ b;
      5: z = 255 - a;
      6: z = (a * (1 << sh)) % 256;
      7: z = a / (1 << sh);
      8: z = ((sa >>> sh) + 256) % 256;
      9: begin
        if (MUL_EN) begin r = a * b; z = r % 256; c = (r > 255); lat = W + 1; end
        else e = 1;
      end
      default: e = 1;
    endcase
    f = e ? 0 : (v * 8 + c * 4 + ((z >= 128) ? 2 : 0) + ((z == 0) ? 1 : 0));
  endtask

  // Issue one op, measure latency, check result, hold for 'hold' cycles, then consume.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o,
                        input int hold, input string nm,
                        input int ez, input int ef, input int ee, input int el);
    int lat;
    bit seen;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.A = a; bus.B = b; bus.op = o;
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    if (!bus.in_ready) begin
      chk({nm, " in_ready timeout"}, 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = 8'($urandom); bus.B = 8'($urandom); bus.op = 4'($urandom);
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin lat = i; seen = 1'b1; break; end
    end
    chk({nm, " latency"}, lat, el);
    if (seen) begin
      chk({nm, " Z"}, int'(bus.Z), ez);
      chk({nm, " flags"}, int'(bus.flags), ef);
      chk({nm, " err"}, int'(bus.err), ee);
      if (hold > 0) begin
        repeat (hold) @(negedge clk);
        chk({nm, " held Z"}, int'(bus.Z), ez);
        chk({nm, " held in_ready"}, int'(bus.in_ready), 0);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ez, ef, ee, el;
    logic [7:0] ra, rb;
    logic [3:0] ro;
    n_pass = 0; n_tot = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.op = '0;

    #12;
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset Z", int'(bus.Z), 0);
    chk("reset flags", int'(bus.flags), 0);
    chk("reset err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flags literal is {V,C,N,Zf}.
    vecs.push_back(mk(8'hFF, 8'h01, 4'd0, 8'h00, 4'b0101, 1'b0, 1, "add_carry"));
    vecs.push_back(mk(8'h7F, 8'h01, 4'd0, 8'h80, 4'b1010, 1'b0, 1, "add_ovf"));
    vecs.push_back(mk(8'h80, 8'h01, 4'd1, 8'h7F, 4'b1100, 1'b0, 1, "sub_ovf"));
    vecs.push_back(mk(8'h01, 8'h02, 4'd1, 8'hFF, 4'b0010, 1'b0, 1, "sub_borrow"));
    vecs.push_back(mk(8'h05, 8'h05, 4'd1, 8'h00, 4'b0101, 1'b0, 1, "sub_equal"));
    vecs.push_back(mk(8'hF0, 8'h3C, 4'd2, 8'h30, 4'b0000, 1'b0, 1, "and"));
    vecs.push_back(mk(8'h0F, 8'h30, 4'd3, 8'h3F, 4'b0000, 1'b0, 1, "or"));
    vecs.push_back(mk(8'h5A, 8'hFF, 4'd4, 8'hA5, 4'b0010, 1'b0, 1, "xor"));
    vecs.push_back(mk(8'h00, 8'h77, 4'd5, 8'hFF, 4'b0010, 1'b0, 1, "not"));
    vecs.push_back(mk(8'h81, 8'h03, 4'd6, 8'h08, 4'b0000, 1'b0, 1, "sll"));
    vecs.push_back(mk(8'h81, 8'h0F, 4'd7, 8'h01, 4'b0000, 1'b0, 1, "srl_amt_mask"));
    vecs.push_back(mk(8'h90, 8'h02, 4'd8, 8'hE4, 4'b0010, 1'b0, 1, "sra_neg"));
    vecs.push_back(mk(8'h70, 8'h04, 4'd8, 8'h07, 4'b0000, 1'b0, 1, "sra_pos"));
    vecs.push_back(mk(8'h12, 8'h34, 4'hF, 8'h00, 4'b0000, 1'b1, 1, "illegal_f"));
    vecs.push_back(mk(8'hAB, 8'hCD, 4'hA, 8'h00, 4'b0000, 1'b1, 1, "illegal_a"));
    vecs.push_back(mk(8'h0F, 8'h11, 4'd9, MUL_EN ? 8'hFF : 8'h00, MUL_EN ? 4'b0010 : 4'b0000,
                      !MUL_EN, MUL_LAT, "mul_0f_11"));
    vecs.push_back(mk(8'h10, 8'h10, 4'd9, 8'h00, MUL_EN ? 4'b0101 : 4'b0000,
                      !MUL_EN, MUL_LAT, "mul_10_10"));
    vecs.push_back(mk(8'hFF, 8'hFF, 4'd9, MUL_EN ? 8'h01 : 8'h00, MUL_EN ? 4'b0100 : 4'b0000,
                      !MUL_EN, MUL_LAT, "mul_ff_ff"));

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, vecs[i].nm,
             int'(vecs[i].z), int'(vecs[i].f), int'(vecs[i].e), vecs[i].lat);

    // Backpressure, then same-cycle accept and back-to-back streaming.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 8'h5A; bus.B = 8'hFF; bus.op = 4'd4;
    @(posedge clk);
    #1;
    bus.A = 8'h01; bus.B = 8'h02; bus.op = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp out_valid", int'(bus.out_valid), 1);
      chk("bp Z", int'(bus.Z), 8'hA5);
      chk("bp flags", int'(bus.flags), 4'b0010);
      chk("bp in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("b2b in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.A = 8'h10; bus.B = 8'h01; bus.op = 4'd1;
    @(negedge clk);
    chk("b2b1 out_valid", int'(bus.out_valid), 1);
    chk("b2b1 Z", int'(bus.Z), 8'h03);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b2 Z", int'(bus.Z), 8'h0F);
    chk("b2b2 flags", int'(bus.flags), 4'b0100);
    @(negedge clk);
    chk("b2b drain out_valid", int'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // Reset during the fourth cycle of a multiply.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 8'h0F; bus.B = 8'h11; bus.op = 4'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mul out_valid", int'(bus.out_valid), 0);
    chk("rst_mul in_ready", int'(bus.in_ready), 1);
    chk("rst_mul Z", int'(bus.Z), 0);
    chk("rst_mul flags", int'(bus.flags), 0);
    chk("rst_mul err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    chk("rst_mul no result", int'(bus.out_valid), 0);
    run_op(8'h01, 8'h01, 4'd0, 0, "post_rst_add", 8'h02, 4'b0000, 0, 1);

    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ro = 4'($urandom_range(0, 15));
      model(int'(ra), int'(rb), int'(ro), ez, ef, ee, el);
      run_op(ra, rb, ro, $urandom_range(0, 2), $sformatf("rnd%0d op%0d", i, ro), ez, ef, ee, el);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
